// File: rtl/cgra_pkg.sv
// Shared CGRA types: writeback FIFO entry layout and the register-file
// defaults it is sized from.
package cgra_pkg;

  localparam int RF_DEPTH     = 4;
  localparam int RF_NSEL      = $clog2(RF_DEPTH);
  localparam int RF_WIDTH     = 32;
  localparam int WB_BUF_DEPTH = 2;

  typedef struct packed {
    logic [RF_NSEL-1:0]  wsel;
    logic [RF_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rc_wb_fifo.sv
// Small synchronous FIFO of writeback entries; exposes every slot and its
// valid bit so the parent can scan pending writes for forwarding.
module rc_wb_fifo
  import cgra_pkg::*;
#(
  parameter  int DEPTH = WB_BUF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  wb_entry_t             wdata_i,
  output wb_entry_t             head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [PTR_W-1:0]      rd_ptr_o,
  output wb_entry_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]      valid_o
);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  wb_entry_t [DEPTH-1:0] mem_q;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; the pointers and count
  // define which slots hold live data, and consumers mask the rest.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offs;
      offs       = PTR_W'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, offs} < cnt_q);
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign rd_ptr_o  = rd_ptr_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/rc_writeback_buf.sv
// RC writeback stage: buffers ALU results for the register file, drains them
// under the CGRA clock-enable, and exports pending/forwarding state.
module rc_writeback_buf
  import cgra_pkg::*;
#(
  parameter int REGFILE_DEPTH = RF_DEPTH,
  parameter int REGFILE_NSEL  = $clog2(REGFILE_DEPTH),
  parameter int REGFILE_WIDTH = RF_WIDTH,
  parameter int BUF_DEPTH     = WB_BUF_DEPTH
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         ce_i,
  input  logic                                         clr_i,
  input  logic                                         res_valid_i,
  input  logic [REGFILE_WIDTH-1:0]                     res_i,
  input  logic [REGFILE_NSEL-1:0]                      res_wsel_i,
  input  logic                                         res_wen_i,
  input  logic                                         res_oen_i,
  output logic                                         ready_o,
  output logic                                         we_o,
  output logic [REGFILE_NSEL-1:0]                      wsel_o,
  output logic [REGFILE_WIDTH-1:0]                     reg_o,
  output logic [REGFILE_WIDTH-1:0]                     rc_out_o,
  output logic [REGFILE_DEPTH-1:0]                     pend_o,
  output logic [REGFILE_DEPTH-1:0][REGFILE_WIDTH-1:0]  fwd_o,
  output logic                                         ovf_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  wb_entry_t                 push_entry, head;
  wb_entry_t [BUF_DEPTH-1:0] entries;
  logic      [BUF_DEPTH-1:0] valid;
  logic      [PTR_W-1:0]     rd_ptr;
  logic                      full, empty, push, pop;
  logic                      ovf_q, ovf_d;
  logic [REGFILE_WIDTH-1:0]  rc_out_q, rc_out_d;

  assign ready_o    = ~full;
  assign we_o       = ~empty;
  assign push       = res_valid_i & res_wen_i & ready_o;
  assign pop        = ce_i & we_o;
  assign push_entry = '{wsel: res_wsel_i, data: res_i};

  rc_wb_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr_i),
    .push_i   (push),
    .pop_i    (pop),
    .wdata_i  (push_entry),
    .head_o   (head),
    .full_o   (full),
    .empty_o  (empty),
    .rd_ptr_o (rd_ptr),
    .entries_o(entries),
    .valid_o  (valid)
  );

  // Head slot contents are undefined while empty, so present zeros instead.
  assign wsel_o = we_o ? head.wsel : '0;
  assign reg_o  = we_o ? head.data : '0;

  // Walk oldest to newest so a later match overrides an earlier one.
  always_comb begin
    pend_o = '0;
    fwd_o  = '0;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      logic [PTR_W-1:0] idx;
      idx = rd_ptr + PTR_W'(k);
      if (valid[idx]) begin
        pend_o[entries[idx].wsel] = 1'b1;
        fwd_o[entries[idx].wsel]  = entries[idx].data;
      end
    end
  end

  always_comb begin
    ovf_d    = ovf_q;
    rc_out_d = rc_out_q;
    if (clr_i) begin
      ovf_d    = 1'b0;
      rc_out_d = '0;
    end else begin
      if (res_valid_i & res_wen_i & ~ready_o) ovf_d = 1'b1;
      if (res_valid_i & res_oen_i)            rc_out_d = res_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q    <= 1'b0;
      rc_out_q <= '0;
    end else begin
      ovf_q    <= ovf_d;
      rc_out_q <= rc_out_d;
    end
  end

  assign ovf_o    = ovf_q;
  assign rc_out_o = rc_out_q;

endmodule

// File: tb/tb_rc_writeback_buf.sv
// Directed self-checking bench for rc_writeback_buf: latency, stall fill,
// overflow, forwarding, back-to-back drain, output register, clear and reset.
module tb_rc_writeback_buf;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             ce_i, clr_i;
  logic             res_valid_i, res_wen_i, res_oen_i;
  logic [31:0]      res_i;
  logic [1:0]       res_wsel_i;
  logic             ready_o, we_o, ovf_o;
  logic [1:0]       wsel_o;
  logic [31:0]      reg_o, rc_out_o;
  logic [3:0]       pend_o;
  logic [3:0][31:0] fwd_o;

  int checks   = 0;
  int failures = 0;

  rc_writeback_buf dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ce_i       (ce_i),
    .clr_i      (clr_i),
    .res_valid_i(res_valid_i),
    .res_i      (res_i),
    .res_wsel_i (res_wsel_i),
    .res_wen_i  (res_wen_i),
    .res_oen_i  (res_oen_i),
    .ready_o    (ready_o),
    .we_o       (we_o),
    .wsel_o     (wsel_o),
    .reg_o      (reg_o),
    .rc_out_o   (rc_out_o),
    .pend_o     (pend_o),
    .fwd_o      (fwd_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    res_valid_i = 1'b0;
    res_wen_i   = 1'b0;
    res_oen_i   = 1'b0;
    clr_i       = 1'b0;
    res_wsel_i  = '0;
    res_i       = '0;
  endtask

  task automatic drive(input logic [1:0] wsel, input logic [31:0] data,
                       input logic wen, input logic oen);
    res_valid_i = 1'b1;
    res_wen_i   = wen;
    res_oen_i   = oen;
    res_wsel_i  = wsel;
    res_i       = data;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    ce_i   = 1'b0;
    idle();
    step();
    checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", we_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", ready_o); end
    checks++; if (pend_o !== 4'b0000) begin failures++; $display("FAIL reset_pend got=%b exp=0000", pend_o); end
    checks++; if (fwd_o !== '0) begin failures++; $display("FAIL reset_fwd got=%0h exp=0", fwd_o); end
    checks++; if ({wsel_o, reg_o, rc_out_o, ovf_o} !== '0) begin failures++;
      $display("FAIL reset_outs wsel=%0h reg=%0h rc_out=%0h ovf=%0h exp all 0", wsel_o, reg_o, rc_out_o, ovf_o); end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    ce_i = 1'b1;
    drive(2'd2, 32'hDEADBEEF, 1'b1, 1'b0);
    #1;
    checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL single_no_comb_we got=%0h exp=0", we_o); end
    step();
    idle();
    checks++; if (we_o !== 1'b1) begin failures++; $display("FAIL single_we got=%0h exp=1", we_o); end
    checks++; if (wsel_o !== 2'd2) begin failures++; $display("FAIL single_wsel got=%0d exp=2", wsel_o); end
    checks++; if (reg_o !== 32'hDEADBEEF) begin failures++; $display("FAIL single_reg got=%0h exp=deadbeef", reg_o); end
    checks++; if (pend_o !== 4'b0100) begin failures++; $display("FAIL single_pend got=%b exp=0100", pend_o); end
    checks++; if (fwd_o[2] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_fwd2 got=%0h exp=deadbeef", fwd_o[2]); end
    step();
    checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL single_drained_we got=%0h exp=0", we_o); end
    checks++; if (pend_o !== 4'b0000) begin failures++; $display("FAIL single_drained_pend got=%b exp=0000", pend_o); end
  endtask

  task automatic test_stall_fill();
    ce_i = 1'b0;
    drive(2'd1, 32'h11, 1'b1, 1'b0);
    step();
    drive(2'd3, 32'h33, 1'b1, 1'b0);
    step();
    idle();
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL stall_ready got=%0h exp=0", ready_o); end
    checks++; if (pend_o !== 4'b1010) begin failures++; $display("FAIL stall_pend got=%b exp=1010", pend_o); end
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL stall_ovf_pre got=%0h exp=0", ovf_o); end
    drive(2'd0, 32'h55, 1'b1, 1'b0);
    step();
    idle();
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL stall_ovf got=%0h exp=1", ovf_o); end
    checks++; if (pend_o !== 4'b1010) begin failures++; $display("FAIL stall_pend_after_ovf got=%b exp=1010", pend_o); end
    ce_i = 1'b1;
    #1;
    checks++; if ({we_o, wsel_o, reg_o} !== {1'b1, 2'd1, 32'h11}) begin failures++;
      $display("FAIL stall_drain0 we=%0h wsel=%0d reg=%0h exp we=1 wsel=1 reg=11", we_o, wsel_o, reg_o); end
    step();
    checks++; if ({we_o, wsel_o, reg_o} !== {1'b1, 2'd3, 32'h33}) begin failures++;
      $display("FAIL stall_drain1 we=%0h wsel=%0d reg=%0h exp we=1 wsel=3 reg=33", we_o, wsel_o, reg_o); end
    step();
    checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL stall_empty_we got=%0h exp=0", we_o); end
    ce_i = 1'b0;
  endtask

  // Leaves two entries buffered, ovf_o set and rc_out_o = 0x99.
  task automatic fill_and_overflow();
    ce_i = 1'b0;
    drive(2'd1, 32'h21, 1'b1, 1'b0);
    step();
    drive(2'd2, 32'h22, 1'b1, 1'b0);
    step();
    drive(2'd3, 32'h99, 1'b1, 1'b1);
    step();
    idle();
  endtask

  task automatic test_clear();
    fill_and_overflow();
    checks++; if ({ovf_o, rc_out_o, pend_o} !== {1'b1, 32'h99, 4'b0110}) begin failures++;
      $display("FAIL clr_setup ovf=%0h rc_out=%0h pend=%b exp ovf=1 rc_out=99 pend=0110", ovf_o, rc_out_o, pend_o); end
    clr_i = 1'b1;
    drive(2'd0, 32'h77, 1'b1, 1'b0);
    step();
    idle();
    checks++; if ({we_o, ovf_o, rc_out_o, pend_o, ready_o} !== {1'b0, 1'b0, 32'h0, 4'b0000, 1'b1}) begin failures++;
      $display("FAIL clr_result we=%0h ovf=%0h rc_out=%0h pend=%b ready=%0h exp we=0 ovf=0 rc_out=0 pend=0000 ready=1",
               we_o, ovf_o, rc_out_o, pend_o, ready_o); end
  endtask

  task automatic test_same_reg_fwd();
    ce_i = 1'b0;
    drive(2'd2, 32'hA, 1'b1, 1'b0);
    step();
    drive(2'd2, 32'hB, 1'b1, 1'b0);
    step();
    idle();
    checks++; if (fwd_o[2] !== 32'hB) begin failures++; $display("FAIL fwd_newest got=%0h exp=b", fwd_o[2]); end
    checks++; if (pend_o !== 4'b0100) begin failures++; $display("FAIL fwd_pend got=%b exp=0100", pend_o); end
    ce_i = 1'b1;
    step();
    ce_i = 1'b0;
    checks++; if ({fwd_o[2], we_o, wsel_o, reg_o} !== {32'hB, 1'b1, 2'd2, 32'hB}) begin failures++;
      $display("FAIL fwd_after_pop fwd2=%0h we=%0h wsel=%0d reg=%0h exp fwd2=b we=1 wsel=2 reg=b", fwd_o[2], we_o, wsel_o, reg_o); end
    ce_i = 1'b1;
    step();
    ce_i = 1'b0;
    checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL fwd_drained_we got=%0h exp=0", we_o); end
  endtask

  task automatic test_back_to_back();
    ce_i = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      drive(2'd0, 32'(v), 1'b1, 1'b0);
      step();
      checks++; if ({we_o, reg_o} !== {1'b1, 32'(v)}) begin failures++;
        $display("FAIL b2b_step%0d we=%0h reg=%0h exp we=1 reg=%0h", v, we_o, reg_o, v); end
    end
    idle();
    step();
    checks++; if ({we_o, ovf_o} !== 2'b00) begin failures++;
      $display("FAIL b2b_end we=%0h ovf=%0h exp we=0 ovf=0", we_o, ovf_o); end
    ce_i = 1'b0;
  endtask

  task automatic test_output_reg();
    ce_i = 1'b0;
    drive(2'd1, 32'h1234, 1'b0, 1'b1);
    step();
    idle();
    checks++; if (rc_out_o !== 32'h1234) begin failures++; $display("FAIL oreg_value got=%0h exp=1234", rc_out_o); end
    checks++; if ({we_o, pend_o, ready_o} !== {1'b0, 4'b0000, 1'b1}) begin failures++;
      $display("FAIL oreg_fifo_empty we=%0h pend=%b ready=%0h exp we=0 pend=0000 ready=1", we_o, pend_o, ready_o); end
  endtask

  task automatic test_async_reset();
    fill_and_overflow();
    checks++; if ({we_o, ovf_o, rc_out_o} !== {1'b1, 1'b1, 32'h99}) begin failures++;
      $display("FAIL arst_setup we=%0h ovf=%0h rc_out=%0h exp we=1 ovf=1 rc_out=99", we_o, ovf_o, rc_out_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if ({we_o, ovf_o, rc_out_o, pend_o, reg_o, wsel_o} !== '0) begin failures++;
      $display("FAIL arst_immediate we=%0h ovf=%0h rc_out=%0h pend=%b reg=%0h wsel=%0h exp all 0",
               we_o, ovf_o, rc_out_o, pend_o, reg_o, wsel_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL arst_ready got=%0h exp=1", ready_o); end
    step();
    rst_ni = 1'b1;
    ce_i   = 1'b1;
    step();
    checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL arst_no_partial_write we=%0h exp=0", we_o); end
    ce_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_stall_fill();
    test_clear();
    test_same_reg_fwd();
    test_back_to_back();
    test_output_reg();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc_writeback_buf.md
Name: rc_writeback_buf

Overview:
Writeback stage between an RC's ALU result path and its register file. It buffers ALU results and their destination register indices in a small FIFO, and drains them as write requests to the register file while the CGRA clock-enable is high. It also drives the RC output register seen by neighbouring RCs. It exports pending-write status and forwarded values so the operand-select logic can bypass writes that have not yet landed.

Parameters:
REGFILE_DEPTH, 4, number of registers in the downstream register file
REGFILE_NSEL, $clog2(REGFILE_DEPTH), register select width
REGFILE_WIDTH, 32, data width
BUF_DEPTH, 2, writeback FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
ce_i  in  1  CGRA clock-enable; drain allowed only when high
clr_i  in  1  synchronous flush at kernel start
res_valid_i  in  1  ALU result valid this cycle
res_i  in  REGFILE_WIDTH  ALU result
res_wsel_i  in  REGFILE_NSEL  destination register index
res_wen_i  in  1  result is to be written to the register file
res_oen_i  in  1  result is to update the RC output register
ready_o  out  1  buffer can accept a write (= not full)
we_o  out  1  write request to the register file (= FIFO not empty)
wsel_o  out  REGFILE_NSEL  head-entry register index
reg_o  out  REGFILE_WIDTH  head-entry data
rc_out_o  out  REGFILE_WIDTH  RC output register to neighbours
pend_o  out  REGFILE_DEPTH  bit r set if any valid entry targets register r
fwd_o  out  REGFILE_DEPTH x REGFILE_WIDTH  per-register newest pending data (0 if not pending)
ovf_o  out  1  sticky overflow error

Behaviour:
- Reset (rst_ni low, asynchronous): FIFO empty, pointers and count 0, rc_out_o=0, ovf_o=0. Consequently we_o=0, ready_o=1, pend_o=0, fwd_o all 0, wsel_o=0, reg_o=0.
- Push condition: res_valid_i & res_wen_i & ready_o, at the clock edge. Entry {res_wsel_i, res_i} is written at the write pointer.
- Pop condition: ce_i & we_o, at the clock edge. This is the same edge at which the register file captures wsel_o/reg_o.
- Latency: a result pushed at edge N appears on we_o/wsel_o/reg_o in cycle N+1 if the FIFO was empty. It lands in the register file at the first edge at or after N+1 where ce_i=1. There is no combinational path from res_* to we_o.
- Push and pop in the same cycle: both take effect; count is unchanged.
  - When full, ready_o=0, so no push occurs even if a pop happens (no same-cycle refill).
- Overflow: res_valid_i & res_wen_i & !ready_o drops the result and sets ovf_o. ovf_o clears only on reset or clr_i.
- Push and pop are independent of ce_i for the input side: a stalled array can still absorb up to BUF_DEPTH results.
- Output register: at any edge with res_valid_i & res_oen_i, rc_out_o <= res_i.
  - It is updated even if the wen part overflows.
  - It is not gated by ce_i.
- Pointers wrap modulo BUF_DEPTH. Count width is $clog2(BUF_DEPTH)+1.
- pend_o/fwd_o are combinational from FIFO state.
  - When multiple valid entries share a register index, fwd_o returns the data of the newest one (closest to the write pointer).
  - An entry being popped this cycle still counts as pending in this cycle.
- clr_i (synchronous, highest priority after reset): empties the FIFO, clears rc_out_o and ovf_o, and ignores a simultaneous push. we_o is 0 in the following cycle.
- Reset asserted mid-operation: all buffered writes are discarded; no partial write is emitted.

Decomposition:
- cgra_pkg gains a wb_entry_t struct typedef {logic [REGFILE_NSEL-1:0] wsel; logic [REGFILE_WIDTH-1:0] data;}, parameterised through package-level localparams matching the register-file defaults, plus a WB_BUF_DEPTH constant.
- One sub-module: rc_wb_fifo (generic synchronous FIFO of wb_entry_t exposing all entries and their valid bits for the pend/fwd scan).
- Forwarding scan and output register stay in the top module.

Test Plan:
- Reset then single write: ce_i=1, push wsel=2, data=0xDEADBEEF → next cycle we_o=1, wsel_o=2, reg_o=0xDEADBEEF; pend_o=4'b0100; fwd_o[2]=0xDEADBEEF; following cycle we_o=0, pend_o=0.
- Stall fill: ce_i=0, push r1=0x11 then r3=0x33 → ready_o=0, pend_o=4'b1010; a third push r0=0x55 sets ovf_o=1 and pend_o is unchanged; ce_i=1 → two writes in order r1, r3 on consecutive cycles.
- Same-register forwarding: ce_i=0, push r2=0xA then r2=0xB → fwd_o[2]=0xB; after one pop (ce_i=1 for one cycle) fwd_o[2]=0xB, wsel_o=2, reg_o=0xB.
- Simultaneous push/pop at count=1: ce_i=1 with a push every cycle of values 1,2,3,4 to r0 → we_o held high, reg_o sequence 1,2,3,4, ovf_o=0.
- Output register: res_oen_i=1, res_wen_i=0, res_i=0x1234 with ce_i=0 → rc_out_o=0x1234 next cycle; FIFO stays empty.
- clr_i and async reset: with 2 entries buffered and ovf_o=1, pulse clr_i → next cycle we_o=0, ovf_o=0, rc_out_o=0. Repeat with rst_ni dropped between edges → outputs clear immediately without a clock edge.
